// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencing controller: Moore FSM stepping fetch/decode/execute/
// memory/writeback with a ready-handshaked unified memory port and a wait timeout.
module multicycle_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic       instr_retired,
  output logic       illegal_instr,
  output logic       mem_err,
  output logic [3:0] state
);

  localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3, MEM_ADDR = 4'd4,
    MEM_RD = 4'd5, MEM_WB = 4'd6, MEM_WR = 4'd7, BRANCH = 4'd8, JAL = 4'd9,
    JALR = 4'd10, LUI = 4'd11, AUIPC = 4'd12, ALU_WB = 4'd13, TRAP = 4'd15
  } state_t;

  // fetch/wr are qualifiers combined with mem_ready for the handshake-dependent outputs
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       pc_write;
    logic       branch;
    logic       pc_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] op;
    logic       reg_write;
    logic [1:0] res;
    logic       retire;
    logic       fetch;
    logic       wr;
  } ctl_t;

  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.mem_req = 1'b1; c.src_b = 2'b10; c.fetch = 1'b1; end
      DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
      EXEC_R:   begin c.src_a = 2'b10; c.op = 2'b10; end
      EXEC_I:   begin c.src_a = 2'b10; c.src_b = 2'b01; c.op = 2'b10; end
      AUIPC:    begin c.src_a = 2'b01; c.src_b = 2'b01; end
      ALU_WB:   begin c.reg_write = 1'b1; c.retire = 1'b1; end
      MEM_ADDR: begin c.src_a = 2'b10; c.src_b = 2'b01; end
      MEM_RD:   begin c.mem_req = 1'b1; c.addr_sel = 1'b1; end
      MEM_WB:   begin c.reg_write = 1'b1; c.res = 2'b01; c.retire = 1'b1; end
      MEM_WR:   begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.addr_sel = 1'b1; c.wr = 1'b1; end
      BRANCH:   begin c.src_a = 2'b10; c.op = 2'b01; c.branch = 1'b1; c.pc_src = 1'b1; c.retire = 1'b1; end
      JAL:      begin c.pc_write = 1'b1; c.pc_src = 1'b1; c.reg_write = 1'b1; c.res = 2'b10; c.retire = 1'b1; end
      JALR:     begin c.src_a = 2'b10; c.src_b = 2'b01; c.pc_write = 1'b1; c.reg_write = 1'b1;
                      c.res = 2'b10; c.retire = 1'b1; end
      LUI:      begin c.reg_write = 1'b1; c.res = 2'b11; c.retire = 1'b1; end
      default:  ;
    endcase
    return c;
  endfunction

  state_t           cur;
  state_t           nxt;
  ctl_t             ctl;
  logic             run;
  logic [CNT_W-1:0] cnt;
  logic             wait_st;
  logic             limit;
  logic             bad_op;

  // run stays low for one cycle after reset so outputs start from all-zero
  always_comb begin
    nxt     = cur;
    bad_op  = 1'b0;
    wait_st = (cur == FETCH) || (cur == MEM_RD) || (cur == MEM_WR);
    limit   = run && wait_st && !mem_ready && (MEM_WAIT_MAX != 0) && (cnt == CNT_LIM);
    if (run) begin
      case (cur)
        FETCH:  if (mem_ready) nxt = DECODE; else if (limit) nxt = TRAP;
        DECODE: begin
          case (opcode)
            OP_R:              nxt = EXEC_R;
            OP_I:              nxt = EXEC_I;
            OP_LOAD, OP_STORE: nxt = MEM_ADDR;
            OP_BR:             nxt = BRANCH;
            OP_JAL:            nxt = JAL;
            OP_JALR:           nxt = JALR;
            OP_LUI:            nxt = LUI;
            OP_AUIPC:          nxt = AUIPC;
            default: begin nxt = TRAP; bad_op = 1'b1; end
          endcase
        end
        EXEC_R, EXEC_I, AUIPC: nxt = ALU_WB;
        MEM_ADDR: nxt = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
        MEM_RD: if (mem_ready) nxt = MEM_WB; else if (limit) nxt = TRAP;
        MEM_WR: if (mem_ready) nxt = FETCH;  else if (limit) nxt = TRAP;
        ALU_WB, MEM_WB, BRANCH, JAL, JALR, LUI: nxt = FETCH;
        TRAP:    nxt = TRAP;
        default: nxt = TRAP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur           <= FETCH;
      ctl           <= '0;
      run           <= 1'b0;
      cnt           <= '0;
      illegal_instr <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      run <= 1'b1;
      cur <= nxt;
      ctl <= decode(nxt);
      if (nxt != cur) cnt <= '0;
      else if (run && wait_st && !mem_ready) cnt <= cnt + 1'b1;
      if (bad_op) illegal_instr <= 1'b1;
      if (limit)  mem_err <= 1'b1;
    end
  end

  assign mem_req       = ctl.mem_req;
  assign mem_we        = ctl.mem_we;
  assign addr_sel      = ctl.addr_sel;
  assign ir_write      = ctl.fetch & mem_ready;
  assign pc_write      = ctl.pc_write | (ctl.fetch & mem_ready);
  assign branch        = ctl.branch;
  assign pc_src        = ctl.pc_src;
  assign alu_src_a     = ctl.src_a;
  assign alu_src_b     = ctl.src_b;
  assign alu_op        = ctl.op;
  assign reg_write     = ctl.reg_write;
  assign result_src    = ctl.res;
  assign instr_retired = ctl.retire | (ctl.wr & mem_ready);
  assign state         = cur;

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Sequencing controller for the multi-cycle variant of the RV32I core. It replaces the single-cycle opcode decoder with a Moore state machine. It steps each instruction through fetch, decode, execute, memory and writeback, and drives a shared ALU and one unified instruction/data memory port. The memory port uses a ready handshake with a timeout. The block sits between the IR opcode field and the datapath mux/enable controls.

## Interface
- MEM_WAIT_MAX, 15: maximum consecutive cycles a memory access may wait with mem_ready low before trapping; 0 disables the timeout.

- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  IR[6:0]. Stable outside FETCH, because the IR is written only in FETCH.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  write request, valid with mem_req.
- addr_sel  out  1  memory address source: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR and oldPC from fetched word/PC.
- pc_write  out  1  unconditional PC update.
- branch  out  1  datapath updates PC if the branch condition holds.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- alu_op  out  2  00 = add, 01 = branch compare, 10 = funct decode.
- reg_write  out  1  register file write enable.
- result_src  out  2  00 = ALUOut, 01 = mem data, 10 = PC, 11 = imm.
- instr_retired  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal_instr  out  1  sticky; unknown opcode seen in DECODE.
- mem_err  out  1  sticky; memory timeout.
- state  out  4  current state encoding, for debug.

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, MEM_ADDR = 4, MEM_RD = 5, MEM_WB = 6
  - MEM_WR = 7, BRANCH = 8, JAL = 9, JALR = 10, LUI = 11, AUIPC = 12, ALU_WB = 13, TRAP = 15
- Outputs are a decode of state, plus mem_ready where noted. Unlisted outputs are 0 and alu_src/alu_op/result_src are 00.
- FETCH:
  - mem_req = 1, addr_sel = 0, alu_src_a = 00, alu_src_b = 10.
  - ir_write and pc_write are asserted only when mem_ready = 1, giving PC = PC + 4.
  - On mem_ready, go to DECODE.
- DECODE:
  - alu_src_a = 01, alu_src_b = 01; ALUOut becomes oldPC + imm.
  - Next state by opcode:
    - 0110011 → EXEC_R; 0010011 → EXEC_I; 0000011 or 0100011 → MEM_ADDR; 1100011 → BRANCH
    - 1101111 → JAL; 1100111 → JALR; 0110111 → LUI; 0010111 → AUIPC
    - anything else → TRAP, and illegal_instr is set.
- EXEC_R: a = 10, b = 00, alu_op = 10 → ALU_WB.
- EXEC_I: a = 10, b = 01, alu_op = 10 → ALU_WB.
- AUIPC: a = 01, b = 01 → ALU_WB.
- ALU_WB: reg_write = 1, result_src = 00 → FETCH.
- MEM_ADDR: a = 10, b = 01 → MEM_RD if opcode = 0000011, else MEM_WR.
- MEM_RD: mem_req = 1, addr_sel = 1; on mem_ready → MEM_WB.
- MEM_WB: reg_write = 1, result_src = 01 → FETCH.
- MEM_WR: mem_req = 1, mem_we = 1, addr_sel = 1; on mem_ready → FETCH.
- BRANCH: a = 10, b = 00, alu_op = 01, branch = 1, pc_src = 1 → FETCH.
- JAL: pc_write = 1, pc_src = 1, reg_write = 1, result_src = 10 → FETCH.
- JALR: a = 10, b = 01, pc_write = 1, pc_src = 0, reg_write = 1, result_src = 10 → FETCH. The datapath clears bit 0 of the target.
- LUI: reg_write = 1, result_src = 11 → FETCH.
- TRAP: all control outputs 0. The FSM stays in TRAP until rst.
- instr_retired = 1 in:
  - ALU_WB, MEM_WB, BRANCH, JAL, JALR, LUI
  - MEM_WR when mem_ready = 1.
- Wait counter (applies in FETCH, MEM_RD, MEM_WR):
  - Width is $clog2(MEM_WAIT_MAX + 1); cleared on entry to each of these states.
  - A cycle with mem_ready = 0 and cnt = MEM_WAIT_MAX − 1 causes a transition to TRAP and sets mem_err. Otherwise cnt increments.
  - mem_ready = 1 always completes the access, even on the limit cycle.

## Timing
- While rst = 1 the state register is FETCH and the counter and sticky flags are 0. All outputs are forced to 0, including mem_req, state = 0 and the flags.
- The first mem_req rises in the cycle after rst falls.
- Reset mid-access aborts immediately. No retirement is signalled, and no partial write is asserted after reset.
- Cycle counts with zero-wait memory:
  - R-type, I-type, AUIPC: 4.
  - Load: 5.
  - Store: 4.
  - Branch, JAL, JALR, LUI: 3.
- Each wait cycle adds 1 per access.
- While waiting, mem_req, mem_we and addr_sel hold stable. No enables (ir_write, pc_write, reg_write) are asserted until the mem_ready cycle.

## Test plan
- ADD (0110011) with mem_ready tied to 1:
  - state sequence is 0, 1, 2, 13, 0.
  - reg_write is high only in cycle 4, together with instr_retired.
- LW with mem_ready low for 2 cycles in MEM_RD:
  - sequence is 0, 1, 4, 5, 5, 5, 6, 0.
  - mem_req = 1 and addr_sel = 1 are held for 3 cycles.
- Opcode 0000000:
  - DECODE goes to TRAP (15) and illegal_instr = 1.
  - The FSM stays in TRAP with mem_req = 0 until rst; afterwards state = 0 and the flag is cleared.
- MEM_WAIT_MAX = 15 with mem_ready held 0 in FETCH:
  - 15 wait cycles are followed by TRAP and mem_err = 1.
- Same timeout setup, but mem_ready = 1 on the 15th cycle:
  - the fetch completes and the FSM goes to DECODE with no mem_err.
- Other cases:
  - SW with rst pulsed on its second wait cycle: outputs go to 0 immediately and instr_retired never pulses.
  - BEQ: BRANCH asserts branch = 1, pc_src = 1, alu_op = 01 for exactly one cycle.
